// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: datapath width, register-address width and
// the default writeback queue depth.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int REG_W     = 5;
  localparam int WBQ_DEPTH = 4;

  typedef logic [REG_W-1:0] reg_addr_t;
endpackage

// File: rtl/wbq_fifo.sv
// Writeback queue storage: circular buffer of {rd, data} with per-entry valid
// bits exported so the top can scan for pending destination registers.
module wbq_fifo
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = riscv_pkg::WBQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [riscv_pkg::REG_W-1:0]       push_rd,
  input  logic [XLEN-1:0]                   push_data,
  input  logic                              pop,
  output logic [riscv_pkg::REG_W-1:0]       head_rd,
  output logic [XLEN-1:0]                   head_data,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [DEPTH-1:0][riscv_pkg::REG_W-1:0] entry_rd,
  output logic [CNT_W-1:0]                  count,
  output logic                              full,
  output logic                              empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0][REG_W-1:0] rd_mem_q;
  logic [XLEN-1:0]  data_mem_q [DEPTH];

  // The top never pops when empty nor pushes when full, so push and pop
  // never target the same slot in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_rd     = rd_mem_q[rd_ptr_q];
  assign head_data   = data_mem_q[rd_ptr_q];
  assign entry_valid = valid_q;
  assign entry_rd    = rd_mem_q;
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue between the ALU/load units and the register file: arbitrates
// producers (load first), drops x0 writes, drains in order and flags hazards.
module regfile_writeback_queue
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = riscv_pkg::WBQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [riscv_pkg::REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [riscv_pkg::REG_W-1:0] ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  input  logic                        wb_stall,
  output logic                        reg_write,
  output logic [riscv_pkg::REG_W-1:0] rd,
  output logic [XLEN-1:0]             write_data,
  input  logic [riscv_pkg::REG_W-1:0] rs1,
  input  logic [riscv_pkg::REG_W-1:0] rs2,
  output logic                        rs1_pending,
  output logic                        rs2_pending,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            count
);

  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_rd;
  reg_addr_t                   head_rd;
  logic [XLEN-1:0]             head_data;
  logic                        accept, push, pop;
  reg_addr_t                   acc_rd;
  logic [XLEN-1:0]             acc_data;

  logic                        reg_write_q, reg_write_d;
  reg_addr_t                   rd_q, rd_d;
  logic [XLEN-1:0]             write_data_q, write_data_d;

  function automatic logic is_pending(
    input reg_addr_t                   rs,
    input logic [DEPTH-1:0]            vld,
    input logic [DEPTH-1:0][REG_W-1:0] ent_rd,
    input logic                        wr_en,
    input reg_addr_t                   wr_rd
  );
    logic hit;
    hit = wr_en && (wr_rd == rs);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (ent_rd[i] == rs)) hit = 1'b1;
    end
    return (rs != '0) && hit;
  endfunction

  // Readiness looks only at registered occupancy: a pop in the same cycle
  // does not free a slot for a producer.
  assign ld_ready  = !reset && !full;
  assign alu_ready = !reset && !full && !ld_valid;

  always_comb begin
    accept   = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    if (ld_valid && ld_ready) begin
      accept   = 1'b1;
      acc_rd   = ld_rd;
      acc_data = ld_data;
    end else if (alu_valid && alu_ready) begin
      accept   = 1'b1;
      acc_rd   = alu_rd;
      acc_data = alu_data;
    end
  end

  assign push = accept && (acc_rd != '0);
  assign pop  = !empty && !wb_stall;

  wbq_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_rd     (acc_rd),
    .push_data   (acc_data),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always_comb begin
    reg_write_d  = pop;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (pop) begin
      rd_d         = head_rd;
      write_data_d = head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;

  assign rs1_pending = is_pending(rs1, entry_valid, entry_rd, reg_write_q, rd_q);
  assign rs2_pending = is_pending(rs2, entry_valid, entry_rd, reg_write_q, rd_q);

endmodule

// File: doc/regfile_writeback_queue.md
REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-003 The block SHALL have one clock and asynchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 alu_valid  in  1  ALU writeback request.
REQ-007 alu_ready  out  1  ALU request accepted this cycle.
REQ-008 alu_rd  in  5  ALU destination register.
REQ-009 alu_data  in  XLEN  ALU result.
REQ-010 ld_valid  in  1  load-unit writeback request.
REQ-011 ld_ready  out  1  load request accepted this cycle.
REQ-012 ld_rd  in  5  load destination register.
REQ-013 ld_data  in  XLEN  load result.
REQ-014 wb_stall  in  1  hold the drain; no dequeue this cycle.
REQ-015 reg_write  out  1  register-file write enable, registered.
REQ-016 rd  out  5  register-file write address, registered.
REQ-017 write_data  out  XLEN  register-file write data, registered.
REQ-018 rs1, rs2  in  5 each  issue-stage source operands to check.
REQ-019 rs1_pending, rs2_pending  out  1 each  source has an outstanding write.
REQ-020 full, empty  out  1 each  queue status.
REQ-021 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-022 Enqueue SHALL accept at most one request per cycle, with ld priority: ld_ready = !full; alu_ready = !full && !ld_valid.
REQ-023 Ready outputs SHALL NOT depend combinationally on wb_stall or on a dequeue in the same cycle; a full queue stalls producers even while draining.
REQ-024 An accepted request with rd == 0 SHALL complete its handshake but SHALL NOT be enqueued; count is unchanged.
REQ-025 Drain: when !empty && !wb_stall, the head SHALL pop and, on the same edge, reg_write <= 1, rd <= head rd and write_data <= head data.
REQ-026 Otherwise reg_write SHALL go to 0 on the next edge; rd and write_data hold their last values.
REQ-027 Latency: a request accepted at edge N into an empty queue SHALL appear on reg_write/rd/write_data after edge N+1, and the register file commits it at edge N+2.
REQ-028 Order: entries SHALL drain strictly in acceptance order, and a later write to the same rd SHALL never commit before an earlier one.
REQ-029 A simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0).
REQ-032 rsX_pending SHALL be 1 iff rsX != 0 and rsX matches any valid queue entry, or matches rd while reg_write == 1.
REQ-033 rsX_pending SHALL be combinational from rsX and registered state only.

Reset
REQ-034 On reset assertion, the block SHALL clear pointers and count, set empty = 1, full = 0 and reg_write = 0, and clear rd, write_data and all entry valid bits, immediately and independent of clk.
REQ-035 Entries in flight at reset SHALL be discarded, with no write issued after reset deasserts.
REQ-036 During reset, alu_ready and ld_ready SHALL be 0.

Structure
REQ-037 XLEN, the 5-bit register address width and the default DEPTH SHALL live in the shared package riscv_pkg.
REQ-038 Storage and pointers SHALL be one sub-module, wbq_fifo, exposing per-entry valid/rd for the pending compare; arbitration, x0 filtering and the output register SHALL stay in the top.

Verification
REQ-039 The bench SHALL cover: ALU write x5 = 0xDEADBEEF into an idle queue -> reg_write = 1, rd = 5, write_data = 0xDEADBEEF exactly two edges after acceptance; rs1 = 5 pending for both cycles.
REQ-040 The bench SHALL cover: ld x10 = 0xCAFEBABE and alu x11 = 0x12345678 both valid in the same cycle -> ld_ready = 1 and alu_ready = 0; x10 commits first, x11 one cycle later.
REQ-041 The bench SHALL cover: write x0 = 0xFFFFFFFF -> handshake completes, count stays 0, reg_write stays 0, and rs1 = 0 is never pending.
REQ-042 The bench SHALL cover: wb_stall = 1 with 4 requests accepted -> full = 1, both readys 0, count = 4; release stall -> four consecutive writes in order, then empty = 1.
REQ-043 The bench SHALL cover: two writes to x7 (0x1, then 0x2) -> commits in order, final write_data = 0x2, and rs2 = 7 pending until the second commit cycle ends.
REQ-044 The bench SHALL cover: reset asserted mid-drain with 3 entries -> count = 0 and reg_write = 0 immediately; no writes after release.
